datapath_sequencer: RTL and testbench
=====================================

Name: datapath_sequencer

Overview:
Shares the s/y datapath between two requesters and sequences it. Each requester asks for one of four datapath operations. The block arbitrates round-robin, latches the winning opcode and drives the datapath control lines (s_en, s_step, s_sub, s_zero, y_en, y_upd, y_select_next) through the operation's micro-sequence. It pulses done back to the winner when the sequence finishes. It sits between the requester logic and the datapath instance, replacing hand-written per-regime control.

Parameters:
COUNT_STEP, 2, s increment used by OP_COUNT (2 bits).
COUNT_REPS, 3, number of increment cycles in OP_COUNT (1..6).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
req  in  2  request per requester; held until done
op0  in  2  opcode of requester 0; stable while req[0]=1
op1  in  2  opcode of requester 1; stable while req[1]=1
s  in  3  current datapath s register value
gnt  out  2  one-hot; owner of the datapath during execution
done  out  2  1-cycle completion pulse to the owner
busy  out  1  high from the grant cycle through the DONE cycle
s_en, s_sub, s_zero  out  1 each  s register control
s_step  out  2  s increment/decrement amount
y_en, y_upd  out  1 each  y register control
y_select_next  out  2  y next-value select

Behaviour:
- All outputs are registered. While rst=0: every output is 0, state is IDLE, round-robin pointer is 0. Reset takes effect immediately, including mid-operation; any in-flight sequence is abandoned and no done pulse is issued.
- Opcodes: 0 NOP, 1 COUNT, 2 DRAIN, 3 LOAD.
- States: IDLE, NOP, COUNT, DRAIN_DEC, DRAIN_CHK, LOAD, DONE.
- Step counter: 3 bits. It is cleared on grant and incremented in COUNT and LOAD.
- Arbitration (IDLE only):
  - If any req is high at an edge, gnt, busy and the first micro-op outputs are asserted at that edge (latency 1 cycle from sampled req).
  - If both are high, the pointer wins. The pointer then moves to the non-winner.
  - If only one is high, it wins and the pointer moves to the other.
  - The opcode is latched at grant. Later changes to op or req are ignored until DONE.
- Micro-op cycles: any control line not listed is 0.
  - NOP: one cycle with all enables 0, then DONE.
  - COUNT:
    - c0: s_en=1, s_zero=1.
    - c1..cCOUNT_REPS: s_en=1, s_step=COUNT_STEP, s_sub=0.
    - Next cycle: idle.
    - Next cycle: s_en=1, s_zero=1.
    - Then DONE.
  - DRAIN: alternates DRAIN_DEC and DRAIN_CHK, starting with DRAIN_DEC.
    - DEC: if s==0, go to DONE with no enable asserted. Otherwise s_en=1, s_step=1, s_sub=1.
    - On the first DEC only, if s==7, also y_en=1, y_upd=1, y_select_next=3.
    - CHK: all enables 0, so the decrement settles before s is re-sampled. Then return to DEC.
    - At most 7 decrements; s cannot underflow.
  - LOAD:
    - c0: y_en=1, y_upd=0.
    - c1: y_en=1, y_upd=1, y_select_next=2.
    - c2: s_en=1, s_step=1, s_sub=0.
    - c3: all enables 0.
    - Then DONE.
- DONE: one cycle. done[owner]=1, gnt=0, busy=1, all enables 0. The next state is IDLE.
- Handshake: the requester must drop req by the first edge after seeing done. A req still high in IDLE is a new request. A req dropped mid-operation does not abort; done is still pulsed.
- Simultaneous events: a req arriving during a busy period waits. A req arriving during DONE is arbitrated in the following IDLE cycle.
- Arithmetic: s_step is zero-extended by the datapath. The s==7 and s==0 comparisons are on the full 3 bits.

Decomposition:
- Shared package:
  - state enum;
  - opcode constants OP_NOP, OP_COUNT, OP_DRAIN, OP_LOAD;
  - y_select_next codes SEL_UPD2=2, SEL_UPD3=3.
- One natural sub-module: rr_arbiter_2. It is a two-input round-robin arbiter with a pointer register, an advance enable and a one-hot grant, using the same clk/rst. The sequencing FSM stays in datapath_sequencer.

Test Plan:
- Reset pulse mid-COUNT (rst=0 at c2) -> all outputs 0 in the same cycle; IDLE afterwards; no done.
- req=01, op0=1 with default parameters:
  - gnt=01 for 6 cycles with the s_en pattern 1,1,1,1,0,1;
  - s_zero high in c0 and c5; s_step=2 in c1..c3;
  - then done=01 for 1 cycle, total busy 7 cycles.
- req=10, op1=2, datapath s=7:
  - first DEC has y_en=1, y_upd=1, y_select_next=3, s_sub=1;
  - 7 DEC/CHK pairs;
  - s==0 sampled -> done=10;
  - no decrement is issued at s=0.
- req=10, op1=2, s=0 -> no enable asserted; done=10 two cycles after grant.
- req=11, both op=3, from reset:
  - requester 0 gets the LOAD sequence (y_en 1,1,0,0; y_select_next=2 at c1; s_en at c2);
  - done=01, then requester 1 is granted in the next IDLE.
- Requester 0 holds req high after done while req[1]=1 -> the pointer grants requester 1; requester 0 is served afterwards.
- Requester 0 drops req and op0 changes mid-LOAD -> the sequence completes unchanged and done=01 is still pulsed.

Source files
------------

// File: rtl/datapath_sequencer_pkg.sv
// Shared definitions for the s/y datapath sequencer.
//   state_e  : sequencer FSM states
//   OP_*     : requester opcodes
//   SEL_*    : y_select_next codes used by the micro-sequences
//   ctrl_t   : bundle of datapath control lines, registered as one unit
package datapath_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NOP,
    ST_COUNT,
    ST_DRAIN_DEC,
    ST_DRAIN_CHK,
    ST_LOAD,
    ST_DONE
  } state_e;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_COUNT = 2'd1;
  localparam logic [1:0] OP_DRAIN = 2'd2;
  localparam logic [1:0] OP_LOAD  = 2'd3;

  localparam logic [1:0] SEL_UPD2 = 2'd2;
  localparam logic [1:0] SEL_UPD3 = 2'd3;

  typedef struct packed {
    logic       s_en;
    logic [1:0] s_step;
    logic       s_sub;
    logic       s_zero;
    logic       y_en;
    logic       y_upd;
    logic [1:0] y_select_next;
  } ctrl_t;

  // First state of each operation's micro-sequence.
  function automatic state_e op_entry_state(input logic [1:0] op);
    state_e st;
    case (op)
      OP_COUNT: st = ST_COUNT;
      OP_DRAIN: st = ST_DRAIN_DEC;
      OP_LOAD:  st = ST_LOAD;
      default:  st = ST_NOP;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/datapath_sequencer_arb.sv
// rr_arbiter_2: two-input round-robin arbiter.
//   clk, rst : clock, asynchronous active-low reset
//   req      : request per requester
//   advance  : the grant is being taken this cycle; move the pointer
//   grant    : one-hot winner (combinational), 0 when no request
// The pointer names the requester that wins a tie; after every taken
// grant it points at the requester that did not win.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q;

  // NOTE: combinational blocks assign every output a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      // Requester 0 won -> point at 1, and vice versa.
      ptr_q <= grant[0];
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: shares the s/y datapath between two requesters.
//   clk, rst        : clock, asynchronous active-low reset
//   req, op0, op1   : requests and their opcodes (held until done)
//   s               : current datapath s register value
//   gnt             : one-hot owner during execution
//   done            : one-cycle completion pulse to the owner
//   busy            : grant cycle through DONE cycle
//   s_en/s_step/s_sub/s_zero, y_en/y_upd/y_select_next : datapath controls
// All outputs are registered: the next-state logic also computes the
// control lines for the state being entered, so they appear at the same
// edge as the state change.
module datapath_sequencer
  import datapath_sequencer_pkg::*;
#(
  parameter logic [1:0] COUNT_STEP = 2'd2,
  parameter int         COUNT_REPS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic [2:0] s,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       busy,
  output logic       s_en,
  output logic       s_sub,
  output logic       s_zero,
  output logic [1:0] s_step,
  output logic       y_en,
  output logic       y_upd,
  output logic [1:0] y_select_next
);

  // COUNT step positions. c0 is recognised by first_q rather than the
  // counter, so COUNT_LAST may wrap to 0 when COUNT_REPS is 6.
  localparam logic [2:0] COUNT_IDLE = 3'(COUNT_REPS + 1);
  localparam logic [2:0] COUNT_LAST = 3'(COUNT_REPS + 2);
  localparam logic [2:0] LOAD_LAST  = 3'd3;

  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic       first_q, first_d;
  logic [1:0] owner_q, owner_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [1:0] gnt_d, done_d;
  logic       busy_d;
  logic [1:0] arb_grant;
  logic       arb_advance;
  logic [1:0] win_op;

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (arb_advance),
    .grant   (arb_grant)
  );

  // Control lines for one cycle of the given state. s_val is the s value
  // sampled at the edge entering that cycle.
  function automatic ctrl_t micro_op(input state_e st, input logic [2:0] step,
                                     input logic first, input logic [2:0] s_val);
    ctrl_t c;
    c = '0;
    case (st)
      ST_COUNT: begin
        if (first || (step == COUNT_LAST)) begin
          c.s_en   = 1'b1;
          c.s_zero = 1'b1;
        end else if (step != COUNT_IDLE) begin
          c.s_en   = 1'b1;
          c.s_step = COUNT_STEP;
        end
      end
      ST_DRAIN_DEC: begin
        // s==0: no decrement; the sequence ends after this cycle.
        if (s_val != 3'd0) begin
          c.s_en   = 1'b1;
          c.s_step = 2'd1;
          c.s_sub  = 1'b1;
          if (first && (s_val == 3'd7)) begin
            c.y_en          = 1'b1;
            c.y_upd         = 1'b1;
            c.y_select_next = SEL_UPD3;
          end
        end
      end
      ST_LOAD: begin
        case (step)
          3'd0: c.y_en = 1'b1;
          3'd1: begin
            c.y_en          = 1'b1;
            c.y_upd         = 1'b1;
            c.y_select_next = SEL_UPD2;
          end
          3'd2: begin
            c.s_en   = 1'b1;
            c.s_step = 2'd1;
          end
          default: c = '0;
        endcase
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign win_op = arb_grant[1] ? op1 : op0;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    first_d     = 1'b0;
    owner_d     = owner_q;
    arb_advance = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          // The opcode is captured by the entry state itself, so later
          // changes on op0/op1 have no effect.
          arb_advance = 1'b1;
          owner_d     = arb_grant;
          step_d      = 3'd0;
          first_d     = 1'b1;
          state_d     = op_entry_state(win_op);
        end
      end
      ST_NOP: state_d = ST_DONE;
      ST_COUNT: begin
        step_d = step_q + 3'd1;
        if (!first_q && (step_q == COUNT_LAST)) state_d = ST_DONE;
      end
      // A DEC cycle without s_en saw s==0 on entry.
      ST_DRAIN_DEC: state_d = ctrl_q.s_en ? ST_DRAIN_CHK : ST_DONE;
      ST_DRAIN_CHK: state_d = ST_DRAIN_DEC;
      ST_LOAD: begin
        step_d = step_q + 3'd1;
        if (step_q == LOAD_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        owner_d = 2'b00;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = 2'b00;
      end
    endcase

    ctrl_d = micro_op(state_d, step_d, first_d, s);
    busy_d = (state_d != ST_IDLE);
    gnt_d  = (state_d != ST_IDLE && state_d != ST_DONE) ? owner_d : 2'b00;
    done_d = (state_d == ST_DONE) ? owner_d : 2'b00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      step_q  <= 3'd0;
      first_q <= 1'b0;
      owner_q <= 2'b00;
      ctrl_q  <= '0;
      gnt     <= 2'b00;
      done    <= 2'b00;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      first_q <= first_d;
      owner_q <= owner_d;
      ctrl_q  <= ctrl_d;
      gnt     <= gnt_d;
      done    <= done_d;
      busy    <= busy_d;
    end
  end

  assign s_en          = ctrl_q.s_en;
  assign s_step        = ctrl_q.s_step;
  assign s_sub         = ctrl_q.s_sub;
  assign s_zero        = ctrl_q.s_zero;
  assign y_en          = ctrl_q.y_en;
  assign y_upd         = ctrl_q.y_upd;
  assign y_select_next = ctrl_q.y_select_next;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer. A transaction-level model
// expands each granted request into its expected per-cycle output list; a
// small s-register model closes the loop from the control lines to s.
module tb_datapath_sequencer;

  localparam logic [1:0] COUNT_STEP = 2'd2;
  localparam int         COUNT_REPS = 3;

  typedef struct packed {
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic       s_en;
    logic [1:0] s_step;
    logic       s_sub;
    logic       s_zero;
    logic       y_en;
    logic       y_upd;
    logic [1:0] y_sel;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] op0 = 2'd0;
  logic [1:0] op1 = 2'd0;
  logic [2:0] s   = 3'd0;
  logic [1:0] gnt, done, s_step, y_select_next;
  logic       busy, s_en, s_sub, s_zero, y_en, y_upd;

  datapath_sequencer #(
    .COUNT_STEP (COUNT_STEP),
    .COUNT_REPS (COUNT_REPS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .op0           (op0),
    .op1           (op1),
    .s             (s),
    .gnt           (gnt),
    .done          (done),
    .busy          (busy),
    .s_en          (s_en),
    .s_sub         (s_sub),
    .s_zero        (s_zero),
    .s_step        (s_step),
    .y_en          (y_en),
    .y_upd         (y_upd),
    .y_select_next (y_select_next)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  obs_t       exp_q[$];
  int         ptr      = 0;
  int         more[2];
  logic [2:0] s_pend   = 3'd0;
  string      phase    = "reset";
  int         cyc      = 0;

  function automatic obs_t obs_now();
    return {gnt, done, busy, s_en, s_step, s_sub, s_zero, y_en, y_upd, y_select_next};
  endfunction

  function automatic obs_t ctl(input int en, input int st, input int sub, input int zero,
                               input int yen, input int yupd, input int ysel);
    obs_t o;
    o        = '0;
    o.s_en   = (en != 0);
    o.s_step = 2'(st);
    o.s_sub  = (sub != 0);
    o.s_zero = (zero != 0);
    o.y_en   = (yen != 0);
    o.y_upd  = (yupd != 0);
    o.y_sel  = 2'(ysel);
    return o;
  endfunction

  // Datapath s register: reacts to the control lines seen in a cycle.
  function automatic logic [2:0] dp_next(input logic [2:0] cur, input obs_t a);
    if (!a.s_en) return cur;
    if (a.s_zero) return 3'd0;
    if (a.s_sub) return cur - {1'b0, a.s_step};
    return cur + {1'b0, a.s_step};
  endfunction

  task automatic check(input string tag, input obs_t act, input obs_t exp);
    n_checks++;
    assert (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push_busy(input obs_t o, input logic [1:0] g);
    o.gnt  = g;
    o.busy = 1'b1;
    exp_q.push_back(o);
  endtask

  // Expected cycles from grant to DONE, plus the mandatory idle cycle.
  task automatic build_txn(input int who, input logic [1:0] opc, input logic [2:0] s0);
    logic [1:0] g;
    obs_t       fin;
    g   = (who == 0) ? 2'b01 : 2'b10;
    fin = '0;
    case (opc)
      2'd0: push_busy(ctl(0, 0, 0, 0, 0, 0, 0), g);
      2'd1: begin
        push_busy(ctl(1, 0, 0, 1, 0, 0, 0), g);
        for (int k = 0; k < COUNT_REPS; k++)
          push_busy(ctl(1, int'(COUNT_STEP), 0, 0, 0, 0, 0), g);
        push_busy(ctl(0, 0, 0, 0, 0, 0, 0), g);
        push_busy(ctl(1, 0, 0, 1, 0, 0, 0), g);
      end
      2'd2: begin
        // One decrement per unit of s, each followed by a settle cycle;
        // then one empty DEC that observes s==0.
        for (int k = int'(s0); k > 0; k--) begin
          if (k == 7) push_busy(ctl(1, 1, 1, 0, 1, 1, 3), g);
          else        push_busy(ctl(1, 1, 1, 0, 0, 0, 0), g);
          push_busy(ctl(0, 0, 0, 0, 0, 0, 0), g);
        end
        push_busy(ctl(0, 0, 0, 0, 0, 0, 0), g);
      end
      default: begin
        push_busy(ctl(0, 0, 0, 0, 1, 0, 0), g);
        push_busy(ctl(0, 0, 0, 0, 1, 1, 2), g);
        push_busy(ctl(1, 1, 0, 0, 0, 0, 0), g);
        push_busy(ctl(0, 0, 0, 0, 0, 0, 0), g);
      end
    endcase
    fin.done = g;
    fin.busy = 1'b1;
    exp_q.push_back(fin);
    exp_q.push_back('0);
  endtask

  // One clock cycle: predict, advance, compare at the falling edge, then
  // let the requesters react to the expected done pulse.
  task automatic tick();
    obs_t e, a;
    int   w;
    if (exp_q.size() == 0) begin
      if (req != 2'b00) begin
        if (req == 2'b11) w = ptr;
        else              w = req[1] ? 1 : 0;
        ptr = 1 - w;
        build_txn(w, (w == 0) ? op0 : op1, s);
      end else begin
        exp_q.push_back('0);
      end
    end
    e = exp_q.pop_front();
    @(posedge clk);
    #1 s = s_pend;
    @(negedge clk);
    cyc++;
    a = obs_now();
    check($sformatf("%s c%0d", phase, cyc), a, e);
    s_pend = dp_next(s, a);
    for (int i = 0; i < 2; i++) begin
      if (e.done[i]) begin
        if (more[i] > 0) begin
          more[i]--;
          if (i == 0) op0 = 2'($urandom_range(0, 3));
          else        op1 = 2'($urandom_range(0, 3));
        end else begin
          req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || req != 2'b00) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s timeout: observed %0d cycles without idle, required fewer", phase, n);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 rst = 1'b0;
    req = 2'b00;
    exp_q.delete();
    ptr  = 0;
    more = '{0, 0};
    s = 3'd0;
    s_pend = 3'd0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    more = '{0, 0};

    // Reset values.
    #2 rst = 1'b0;
    #1 check("reset_async", obs_now(), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    phase = "idle_after_reset";
    repeat (2) tick();

    // COUNT from requester 0.
    phase = "count_r0";
    s = 3'd5; s_pend = s;
    op0 = 2'd1; req = 2'b01;
    run_until_idle(40);

    // Reset asserted at c2 of COUNT: outputs clear at once, no done later.
    phase = "count_mid";
    op0 = 2'd1; req = 2'b01;
    repeat (3) tick();
    rst = 1'b0;
    #1 check("reset_mid_count", obs_now(), '0);
    req = 2'b00;
    exp_q.delete();
    ptr = 0;
    more = '{0, 0};
    s = 3'd0; s_pend = 3'd0;
    @(negedge clk);
    rst = 1'b1;
    phase = "after_mid_reset";
    repeat (3) tick();

    // DRAIN from s=7: y update on first DEC, seven DEC/CHK pairs.
    phase = "drain_s7";
    s = 3'd7; s_pend = s;
    op1 = 2'd2; req = 2'b10;
    run_until_idle(60);

    // DRAIN from s=0: no enables at all.
    phase = "drain_s0";
    s = 3'd0; s_pend = s;
    op1 = 2'd2; req = 2'b10;
    run_until_idle(20);

    // Both requesters LOAD from reset: requester 0 first.
    reset_pulse();
    phase = "load_both";
    op0 = 2'd3; op1 = 2'd3; req = 2'b11;
    run_until_idle(40);

    // Requester 0 re-requests straight after done while requester 1 waits.
    phase = "hold_r0";
    op0 = 2'd1; op1 = 2'd0; more[0] = 1; req = 2'b11;
    run_until_idle(60);

    // Requester 0 drops req and changes op during LOAD.
    phase = "drop_mid_load";
    op0 = 2'd3; req = 2'b01;
    repeat (2) tick();
    req[0] = 1'b0;
    op0 = 2'd1;
    run_until_idle(30);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      phase = $sformatf("rand%0d", it);
      s = 3'($urandom_range(0, 7)); s_pend = s;
      op0 = 2'($urandom_range(0, 3));
      op1 = 2'($urandom_range(0, 3));
      more[0] = $urandom_range(0, 1);
      more[1] = $urandom_range(0, 1);
      req = 2'($urandom_range(1, 3));
      if (req[0] == 1'b0) more[0] = 0;
      if (req[1] == 1'b0) more[1] = 0;
      run_until_idle(300);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
